// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Brief   : Shared types and default widths for the mem_arbiter slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_starve.sv
// ============================================================================
// Module  : mem_arb_starve
// Brief   : Saturating count of port-B wins while port A waits; forces A.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic a_wait,
    input  logic b_win,
    input  logic a_win,
    output logic force_a
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] C_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    // An IDLE cycle with A not asking clears the count, so only back-to-back waits accumulate
    always_comb begin
        starve_d = starve_q;
        if (a_win || (idle && !a_wait)) begin
            starve_d = '0;
        end else if (a_wait && b_win && (starve_q != C_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_a = (starve_q == C_MAX);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Brief   : Fetch (A) / load-store (B) arbiter and sequencer for mem.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    output logic          a_gnt,
    output logic          a_valid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_valid,
    output logic [DW-1:0] b_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic [DW-1:0] a_hold_q, b_hold_q;

    logic w_idle, w_busy, w_force_a, w_a_win, w_b_win;

    // rst gating keeps grants and strobes low the moment reset asserts, mid-cycle included
    assign w_idle  = rst && (state_q == IDLE);
    assign w_busy  = rst && (state_q == BUSY);
    assign w_b_win = w_idle && b_req && !(w_force_a && a_req);
    assign w_a_win = w_idle && a_req && !w_b_win;

    mem_arb_starve #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .idle    (w_idle),
        .a_wait  (w_idle && a_req),
        .b_win   (w_b_win),
        .a_win   (w_a_win),
        .force_a (w_force_a)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_A;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (w_a_win || w_b_win) begin
                    state_d = BUSY;
                    owner_d = w_b_win ? OWN_B : OWN_A;
                    we_d    = w_b_win && b_we;
                end
            end
            BUSY:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_gnt     = w_a_win;
        b_gnt     = w_b_win;
        mem_read  = w_a_win || (w_b_win && !b_we);
        mem_write = w_b_win && b_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_a_win) begin
            mem_addr = a_addr;
        end else if (w_b_win) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
        a_valid = w_busy && (owner_q == OWN_A);
        b_valid = w_busy && (owner_q == OWN_B);
        a_rdata = a_valid ? mem_rdata : a_hold_q;
        b_rdata = (b_valid && !we_q) ? mem_rdata : b_hold_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else if (w_busy && !we_q) begin
            if (owner_q == OWN_A) begin
                a_hold_q <= mem_rdata;
            end else begin
                b_hold_q <= mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-ported `mem` data memory. It shares the memory between an instruction-fetch requester (port A, read-only) and a load/store requester (port B, read/write). It also sequences each access into the memory's strobe/address/data protocol and returns read data with a valid pulse. It sits between the core's fetch and execute stages and `mem`, and is the only driver of `mem`'s inputs.

## Interface
- `AW`, 16, address width (matches `mem` address)
- `DW`, 16, data word width (matches `mem` dataIn/dataOut)
- `STARVE_MAX`, 4, number of consecutive port-B wins while A waits before A is forced to win
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `a_req`  in  1  fetch request; held with `a_addr` stable until `a_gnt`
- `a_addr`  in  AW  fetch byte address
- `a_gnt`  out  1  fetch request accepted this cycle
- `a_valid`  out  1  one-cycle pulse; `a_rdata` valid
- `a_rdata`  out  DW  fetch read data
- `b_req`  in  1  load/store request; held with `b_we`/`b_addr`/`b_wdata` stable until `b_gnt`
- `b_we`  in  1  1 = write, 0 = read
- `b_addr`  in  AW  load/store byte address
- `b_wdata`  in  DW  store data
- `b_gnt`  out  1  load/store request accepted this cycle
- `b_valid`  out  1  one-cycle pulse; read data valid, or write committed
- `b_rdata`  out  DW  load read data
- `mem_read`, `mem_write`  out  1  strobes to `mem` memRead/memWrite
- `mem_addr`, `mem_wdata`  out  AW/DW  to `mem` address/dataIn
- `mem_rdata`  in  DW  from `mem` dataOut

## Operation
- FSM with two states:
  - IDLE: the only state that accepts requests.
  - BUSY: the response cycle; all requests are ignored.
- IDLE, any request pending:
  - Select a winner.
  - Assert its `gnt` combinationally in the same cycle.
  - Drive `mem_addr`/`mem_wdata` and `mem_read` (read) or `mem_write` (B write) from the winner in that cycle.
  - Latch the owner and the operation; go to BUSY at the next edge.
- BUSY:
  - Pulse the owner's `valid`.
  - For a read, the owner's `rdata` = `mem_rdata` (passthrough), also captured into that port's hold register.
  - Go to IDLE at the next edge.
- `x_rdata` outside the valid cycle holds the last captured value. Reset value is 0.
- Writes still pulse `b_valid` in BUSY. `b_rdata` is unchanged by writes.
- Arbitration: B has fixed priority, with an anti-starvation counter `starve`:
  - Width is clog2(STARVE_MAX+1).
  - `starve` increments when A requests in IDLE and B wins.
  - `starve` clears when A wins, or in any IDLE cycle with `a_req`=0.
  - `starve` saturates at STARVE_MAX.
  - When `starve`==STARVE_MAX and `a_req`=1, A wins even if `b_req`=1.
- A is never granted a write. `mem_write` is only ever asserted for B.
- Requesters must drop `req` on the edge after `gnt`. A `req` still high when IDLE returns is a new request.
- Idle outputs: `mem_read`/`mem_write`/`gnt`/`valid`=0. `mem_addr`/`mem_wdata`=0.

## Timing
- Throughput: one access per 2 cycles.
- Latency: `gnt` in cycle N; `valid` and data in cycle N+1.
- A request raised during BUSY gets its earliest grant in the cycle after `valid`.
- `mem` registers the read address at the edge ending cycle N. `dataOut` is therefore valid throughout cycle N+1; no extra wait state.
- Write: `mem` commits at the edge ending cycle N. A read granted at cycle N+2 observes the new data.
- Simultaneous `a_req` and `b_req` in IDLE: B wins unless `starve`==STARVE_MAX.
- Reset (asserted at any time, including in BUSY):
  - State goes to IDLE and `starve` to 0; hold registers clear to 0.
  - All outputs are 0, including the combinational `gnt` and mem strobes, which are gated by `rst`.
  - An in-flight access produces no `valid`; its requester must re-request.
  - A write granted in the cycle reset asserts is not issued.
- Addresses pass through unmodified, odd or even. The address range is `mem`'s responsibility.

## Structure
- Package `mem_arbiter_pkg`:
  - state enum {IDLE, BUSY}
  - owner encoding {OWN_A, OWN_B}
  - default widths AW/DW
- One natural sub-module: `mem_arb_starve`, the saturating anti-starvation counter. Inputs are a_wait/b_win/a_win; output is `force_a`.
- Top level: FSM, winner mux, mem-side mux and the two read hold registers.

## Test plan
- After reset, A reads addr 0x0000 → `a_gnt` in cycle N, `a_valid`=1 and `a_rdata`=16'hAB99 in N+1 (`mem` reset contents bytes 0/1 = 8'hAB/8'h99).
- B writes 16'h1234 to 0x0010, then A reads 0x0010 → `b_valid` in N+1; `a_rdata`=16'h1234 two cycles later.
- A and B request together, B reads 0x0000 → `b_gnt` first and `b_rdata`=16'hAB99; A granted in the cycle after `b_valid`.
- B requests continuously while A waits, STARVE_MAX=4 → B wins 4 times, then A wins 5th; `starve` returns to 0.
- Reset asserted in BUSY of an A read → `a_valid` never pulses, all outputs 0, `a_rdata`=0 after reset.
- B write granted with reset asserting the same cycle → memory word unchanged (a later read returns the prior value).
